axis_rr_arbiter: RTL

- Shares one AXI-Stream output between N_S AXI-Stream source ports, one packet at a time.
- Round-robin arbitration with packet lock: once a source is granted, the grant holds until that source's tlast beat handshakes.
- Sits between several packet producers (e.g. per-channel engines) and a single shared consumer such as a DMA writer or output FIFO.
- Data path is a combinational mux on the granted port. Control (grant, pointer, state, counters) is registered.

---
 rtl/axis_arb_pkg.sv | 29 ++
 rtl/axis_rr_arbiter_rr_picker.sv | 30 +++
 rtl/axis_rr_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/axis_arb_pkg.sv
// Shared types, default configuration and width helpers for the AXI-Stream
// round-robin packet arbiter.
package axis_arb_pkg;

    localparam int DEF_WORD_W = 8;
    localparam int DEF_BUS_W  = 8;
    localparam int DEF_N_S    = 4;
    localparam int DEF_CNT_W  = 16;

    function automatic int calc_words_per_beat(input int bus_w, input int word_w);
        return bus_w / word_w;
    endfunction

    // A single-source arbiter still needs a 1-bit grant/tdest field.
    function automatic int calc_grant_w(input int n_s);
        return (n_s > 1) ? $clog2(n_s) : 1;
    endfunction

    localparam int WORDS_PER_BEAT = calc_words_per_beat(DEF_BUS_W, DEF_WORD_W);
    localparam int GRANT_W        = calc_grant_w(DEF_N_S);

    typedef logic [WORDS_PER_BEAT-1:0][DEF_WORD_W-1:0] beat_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/axis_rr_arbiter_rr_picker.sv
// Combinational round-robin search: first asserted request at or after ptr,
// wrapping modulo N_S.
module rr_picker #(
    parameter int N_S     = 4,
    parameter int GRANT_W = 2
) (
    input  logic [N_S-1:0]     req,
    input  logic [GRANT_W-1:0] ptr,
    output logic               found,
    output logic [GRANT_W-1:0] idx
);

    logic [GRANT_W-1:0] cand;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int i = 0; i < N_S; i++) begin
            cand = (int'(ptr) + i >= N_S) ? GRANT_W'(int'(ptr) + i - N_S)
                                          : GRANT_W'(int'(ptr) + i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Shares one AXI-Stream output between N_S sources, one whole packet at a time,
// with round-robin fairness and a combinational data mux on the granted port.
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int  WORD_W         = DEF_WORD_W,
    parameter int  BUS_W          = DEF_BUS_W,
    parameter int  N_S            = DEF_N_S,
    parameter int  CNT_W          = DEF_CNT_W,
    localparam int WORDS_PER_BEAT = calc_words_per_beat(BUS_W, WORD_W),
    localparam int GRANT_W        = calc_grant_w(N_S)
) (
    input  logic                                         clk,
    input  logic                                         rstn,
    input  logic [N_S-1:0]                               s_valid,
    output logic [N_S-1:0]                               s_ready,
    input  logic [N_S-1:0][WORDS_PER_BEAT-1:0][WORD_W-1:0] s_data,
    input  logic [N_S-1:0][WORDS_PER_BEAT-1:0]           s_keep,
    input  logic [N_S-1:0]                               s_last,
    output logic                                         m_valid,
    input  logic                                         m_ready,
    output logic [WORDS_PER_BEAT-1:0][WORD_W-1:0]        m_data,
    output logic [WORDS_PER_BEAT-1:0]                    m_keep,
    output logic                                         m_last,
    output logic [GRANT_W-1:0]                           m_sel,
    output logic                                         busy,
    output logic [CNT_W-1:0]                             pkt_beats,
    output logic [CNT_W-1:0]                             pkt_count
);

    state_t             state_q, state_d;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic [GRANT_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]   pkt_beats_q, pkt_beats_d;
    logic [CNT_W-1:0]   pkt_count_q, pkt_count_d;

    logic               pick_found;
    logic [GRANT_W-1:0] pick_idx;
    logic               beat_fire;
    logic               pkt_end;

    rr_picker #(
        .N_S     (N_S),
        .GRANT_W (GRANT_W)
    ) u_picker (
        .req   (s_valid),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Only the granted port sees m_ready; the others are held off even when valid.
    always_comb begin
        s_ready = '0;
        m_valid = 1'b0;
        m_data  = 'x;
        m_keep  = 'x;
        m_last  = 1'bx;
        if (state_q == BUSY) begin
            m_valid          = s_valid[grant_q];
            m_data           = s_data[grant_q];
            m_keep           = s_keep[grant_q];
            m_last           = s_last[grant_q];
            s_ready[grant_q] = m_ready;
        end
    end

    assign beat_fire = m_valid & m_ready;
    assign pkt_end   = beat_fire & m_last;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        pkt_beats_d = pkt_beats_q;
        pkt_count_d = pkt_count_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = BUSY;
                    grant_d     = pick_idx;
                    pkt_beats_d = '0;
                end
            end
            BUSY: begin
                if (pkt_end) begin
                    state_d     = IDLE;
                    ptr_d       = (grant_q == GRANT_W'(N_S - 1)) ? '0 : grant_q + 1'b1;
                    pkt_count_d = pkt_count_q + 1'b1;
                    pkt_beats_d = '0;
                end else if (beat_fire && (pkt_beats_q != '1)) begin
                    pkt_beats_d = pkt_beats_q + 1'b1;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            ptr_q       <= '0;
            pkt_beats_q <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            pkt_beats_q <= pkt_beats_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign busy      = (state_q == BUSY);
    assign m_sel     = grant_q;
    assign pkt_beats = pkt_beats_q;
    assign pkt_count = pkt_count_q;

endmodule
